// File: rtl/wb_lcd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_lcd_ctrl_if
// Brief    : Wishbone classic slave bundle for the wb_lcd_ctrl LCD sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface wb_lcd_ctrl_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wb_lcd_ctrl
// Brief    : Wishbone slave that queues HD44780 bytes in a FIFO and plays each
//            one out as a timed RS/Data/E cycle. Define LCD_INIT_EN to add the
//            autonomous power-on initialisation sequence.
// Revision : 1.0  initial release
// ============================================================================
module wb_lcd_ctrl #(
  parameter int CLK_FREQ    = 100000000,
  parameter int FIFO_AW     = 3,
  parameter int E_SETUP_CYC = 5,
  parameter int E_HIGH_CYC  = 25
) (
  input  logic         clk,
  input  logic         rst,
  wb_lcd_ctrl_if.slave wb,
  output logic         intr,
  output logic         E,
  output logic         RS,
  output logic         RW,
  output logic [7:0]   Data_out
);

  localparam int DEPTH   = 2**FIFO_AW;
  localparam int LVL_W   = FIFO_AW + 1;
  localparam int SETUP_N = (E_SETUP_CYC < 1) ? 1 : E_SETUP_CYC;
  localparam int HIGH_N  = (E_HIGH_CYC < 1) ? 1 : E_HIGH_CYC;
  localparam int LONG_N  = (CLK_FREQ / 600 < 1) ? 1 : CLK_FREQ / 600;
  localparam int SHORT_N = (CLK_FREQ / 25000 < 1) ? 1 : CLK_FREQ / 25000;
  localparam int PWR_N   = (CLK_FREQ / 66 < 1) ? 1 : CLK_FREQ / 66;
  localparam int MAX_A   = (SETUP_N > HIGH_N) ? SETUP_N : HIGH_N;
  localparam int MAX_B   = (LONG_N > SHORT_N) ? LONG_N : SHORT_N;
  localparam int MAX_C   = (PWR_N > MAX_A) ? PWR_N : MAX_A;
  localparam int MAX_N   = (MAX_B > MAX_C) ? MAX_B : MAX_C;
  localparam int CNT_W   = $clog2(MAX_N + 1);

  localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(SETUP_N - 1);
  localparam logic [CNT_W-1:0] C_HIGH  = CNT_W'(HIGH_N - 1);
  localparam logic [CNT_W-1:0] C_LONG  = CNT_W'(LONG_N - 1);
  localparam logic [CNT_W-1:0] C_SHORT = CNT_W'(SHORT_N - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
`ifdef LCD_INIT_EN
    , ST_INIT = 3'd5
`endif
  } state_t;

`ifdef LCD_INIT_EN
  localparam state_t           ST_RESET = ST_INIT;
  localparam logic [CNT_W-1:0] C_RESET  = CNT_W'(PWR_N - 1);
  localparam logic [2:0]       INIT_LEN = 3'd6;
`else
  localparam state_t           ST_RESET = ST_IDLE;
  localparam logic [CNT_W-1:0] C_RESET  = '0;
`endif

  // ---------------------------------------------------------------- bus side
  logic        ack_q, ack_d;
  logic [31:0] dat_o_q, dat_o_d;
  logic        ovf_q, ovf_d;
  logic        irq_en_q, irq_en_d;
  logic        req, wr_fire, push_req, ctrl_wr, stat_rd, flush;
  logic [1:0]  reg_sel;
  logic [31:0] status_word;
  logic        unused_bits;

  // ---------------------------------------------------------------- FIFO
  logic [8:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               empty, full, pop, push_ok, ovf_set;
  logic [8:0]         head;

  // ---------------------------------------------------------------- sequencer
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             e_q, e_d;
  logic             busy, is_long;

  assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                         wb.wb_dat_i[31:9]};

  assign reg_sel  = wb.wb_adr_i[3:2];
  assign req      = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  // Writes take effect in the ack cycle; reads are captured as ack rises.
  assign wr_fire  = ack_q & wb.wb_stb_i & wb.wb_cyc_i & wb.wb_we_i;
  assign push_req = wr_fire & (reg_sel == 2'd0);
  assign ctrl_wr  = wr_fire & (reg_sel == 2'd2);
  assign stat_rd  = req & ~wb.wb_we_i & (reg_sel == 2'd1);
  assign flush    = ctrl_wr & wb.wb_dat_i[1];

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;

  assign busy    = (state_q != ST_IDLE);
  assign is_long = ~rs_q & ((data_q == 8'h01) | (data_q == 8'h02) | (data_q == 8'h03));

  always_comb begin
    status_word       = '0;
    status_word[0]    = busy;
    status_word[1]    = empty;
    status_word[2]    = full;
    status_word[3]    = ovf_q;
    status_word[11:8] = 4'(level_q);
  end

  always_comb begin
    ack_d    = req;
    dat_o_d  = '0;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    if (req && !wb.wb_we_i) begin
      case (reg_sel)
        2'd1:    dat_o_d = status_word;
        2'd2:    dat_o_d = {31'd0, irq_en_q};
        default: dat_o_d = '0;
      endcase
    end
    if (stat_rd) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
    if (ctrl_wr) irq_en_d = wb.wb_dat_i[0];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push_ok) level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wb.wb_dat_i[8:0];
  end

`ifdef LCD_INIT_EN
  logic [2:0] init_idx_q, init_idx_d;
  logic [7:0] init_byte;

  always_comb begin
    case (init_idx_q)
      3'd0, 3'd1, 3'd2: init_byte = 8'h38;
      3'd3:             init_byte = 8'h0C;
      3'd4:             init_byte = 8'h06;
      default:          init_byte = 8'h01;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) init_idx_q <= '0;
    else      init_idx_q <= init_idx_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    pop     = 1'b0;
`ifdef LCD_INIT_EN
    init_idx_d = init_idx_q;
`endif
    case (state_q)
`ifdef LCD_INIT_EN
      ST_INIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (init_idx_q == INIT_LEN) begin
          state_d = ST_IDLE;
        end else begin
          rs_d       = 1'b0;
          data_d     = init_byte;
          init_idx_d = init_idx_q + 1'b1;
          cnt_d      = C_SETUP;
          state_d    = ST_SETUP;
        end
      end
`endif
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          rs_d    = head[8];
          data_d  = head[7:0];
          cnt_d   = C_SETUP;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          cnt_d   = C_HIGH;
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          cnt_d   = C_SETUP;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          cnt_d   = is_long ? C_LONG : C_SHORT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
`ifdef LCD_INIT_EN
          if (init_idx_q != INIT_LEN) begin
            cnt_d   = '0;
            state_d = ST_INIT;
          end else
`endif
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // E is registered from the next state so it tracks PULSE without glitches.
    e_d = (state_d == ST_PULSE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q    <= 1'b0;
      dat_o_q  <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= ST_RESET;
      cnt_q    <= C_RESET;
      rs_q     <= 1'b0;
      data_q   <= '0;
      e_q      <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      dat_o_q  <= dat_o_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
      e_q      <= e_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_o_q;
  assign intr        = irq_en_q & (state_q == ST_IDLE) & empty;
  assign E           = e_q;
  assign RS          = rs_q;
  assign RW          = 1'b0;
  assign Data_out    = data_q;

endmodule
`default_nettype wire
